bcd_display_mux: RTL and testbench
==================================

# bcd_display_mux

Display-side consumer for the BCD counters. It takes four packed BCD digits, latches them once per refresh frame, and scans them onto a 4-digit, common-anode, multiplexed seven-segment display. Digits are shown one at a time, with decoding, optional leading-zero blanking, per-digit decimal points, and a visible dash for invalid codes. The counter outputs feed `digits`; `an`, `seg` and `dp` go straight to the board pins.

## Interface
- REFRESH_DIV, 4: clock cycles each digit stays selected.
  - Minimum value is 2.
  - Board builds use 50000.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high; dominates all other inputs.
- en  input  1  scan enable; when low, all state holds.
- digits  input  16  BCD digits; digit i is `digits[4i+3:4i]`; digit 3 is the most significant.
- dp_in  input  4  decimal point request per digit; bit i belongs to digit i.
- blank_lz  input  1  leading-zero blanking enable.
- an  output  4  active-low anode select; `an[i]=0` lights digit i.
- seg  output  7  active-low segments `{g,f,e,d,c,b,a}`.
- dp  output  1  active-low decimal point.
- frame_done  output  1  one-cycle pulse at each frame wrap.

## Operation
- State:
  - `div_cnt`: width clog2(REFRESH_DIV).
  - `idx`: 2 bits, the selected digit.
  - `active` flag.
  - `shadow`: 16 bits, latched digits.
  - `dp_sh`: 4 bits, latched decimal points.
- Reset values:
  - All state is 0.
  - `an=4'hF`, `seg=7'h7F`, `dp=1`, `frame_done=0`.
- Start-up: the first edge with `en=1` after reset:
  - sets `active`;
  - loads `shadow<=digits` and `dp_sh<=dp_in`;
  - selects digit 0 with `div_cnt=0`.
  - `frame_done` does not pulse on this edge.
- Scan, on each edge with `en=1` and `active=1`:
  - If `div_cnt < REFRESH_DIV-1`: increment `div_cnt`.
  - Otherwise: set `div_cnt=0` and advance `idx` through 0→1→2→3→0.
- Frame wrap (edge where `idx` goes 3→0):
  - `shadow` and `dp_sh` reload from the inputs.
  - `frame_done` is 1 for the following cycle.
  - Input changes at any other time are not displayed until the next wrap, so no tearing.
- Decode of `shadow` nibble to `seg`:
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19
  - 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10
  - 10–15 show a dash, 7'h3F (g segment only).
- Leading-zero blanking (`blank_lz=1`):
  - Digit i (i=3,2,1) is blanked when its nibble and every higher nibble are 0, and `dp_sh[i]=0`.
  - A set decimal point forces that digit and all lower digits to display (e.g. 0007 with dp on digit 2 shows " 0.07").
  - Digit 0 is never blanked.
  - `blank_lz` is sampled live, not shadowed.
- Blanked slot: `an=4'hF`, `seg=7'h7F`, `dp=1`. The slot still occupies its REFRESH_DIV cycles.
- Normal slot:
  - `an` is all ones except bit `idx`, which is 0.
  - `seg` is the decode of the selected nibble.
  - `dp=~dp_sh[idx]`.
- `en=0`:
  - `div_cnt`, `idx`, shadow and outputs hold.
  - No `frame_done` pulse.
  - Before start-up, outputs stay in their reset values.
- Reset mid-frame: the next edge returns all state and outputs to reset values, regardless of `en`.

## Timing
- `an`, `seg`, `dp` and `frame_done` are registered. They reflect the `idx` and shadow values in effect after the same edge, with no extra cycle of lag.
- With `en` held high, each digit slot lasts exactly REFRESH_DIV cycles.
- A frame lasts 4·REFRESH_DIV cycles; `frame_done` pulses once per frame.
- Latency from a `digits` change to display:
  - appears at the next wrap edge, if it is set up before that edge;
  - worst case is 4·REFRESH_DIV cycles.
- A wrap edge with `en=0` is deferred: it occurs on the first later edge with `en=1`.

## Test plan
- Reset:
  - Stimulus: hold `reset` 3 cycles with `en=1`.
  - Required: `an=4'hF`, `seg=7'h7F`, `dp=1`, `frame_done=0` throughout.
- Basic scan:
  - Stimulus: REFRESH_DIV=4, `digits=16'h1234`, `dp_in=0`, `blank_lz=0`, `en=1`.
  - Required sequence, each slot held 4 cycles, repeating:
    - `an=1110`, `seg=7'h19`
    - `an=1101`, `seg=7'h30`
    - `an=1011`, `seg=7'h24`
    - `an=0111`, `seg=7'h79`
  - `frame_done` high for exactly 1 cycle every 16 cycles, aligned with the return to `an=1110`.
- Shadowing:
  - Stimulus: change `digits` to `16'h5678` during digit 1 of a frame.
  - Required: the rest of that frame shows 3, 2, 1; the next frame shows 8, 7, 6, 5.
- Blanking and decimal point:
  - Stimulus: `digits=16'h0007`, `blank_lz=1`, `dp_in=4'b0100`.
  - Required:
    - slot 3: `an=4'hF`;
    - slot 2: `seg=7'h40`, `dp=0`;
    - slot 1: `seg=7'h40`, `dp=1`;
    - slot 0: `seg=7'h78`.
  - Then with `dp_in=0`: slots 3, 2 and 1 all blank.
- Invalid codes:
  - Stimulus: `digits=16'hF0C9`, `blank_lz=0`.
  - Required: digit 0 `seg=7'h10`; digit 1 `7'h3F`; digit 2 `7'h40`; digit 3 `7'h3F`.
- Enable and mid-frame reset:
  - Stimulus: drop `en` for 5 cycles during digit 2.
  - Required: outputs frozen; the slot resumes with its remaining cycles.
  - Stimulus: then assert `reset` mid-frame for 1 cycle.
  - Required: the next edge gives reset values; the first enabled edge afterwards restarts at digit 0 with newly latched `digits`.

Source files
------------

// File: rtl/bcd_display_mux.sv
// Four-digit multiplexed seven-segment driver for packed BCD.
// Digits are latched once per frame so a scan never mixes two values.
module bcd_display_mux #(
   parameter int REFRESH_DIV = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [15:0] digits,
   input  logic [3:0]  dp_in,
   input  logic        blank_lz,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_done
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);

   logic [CW-1:0] div_cnt_q, div_cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic          active_q;
   logic [15:0]   shadow_q, shadow_d;
   logic [3:0]    dp_sh_q, dp_sh_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic          fd_q;
   logic          load, wrap, blank;
   logic [3:0]    nib;

   always_comb begin
      div_cnt_d = div_cnt_q;
      idx_d     = idx_q;
      load      = 1'b0;
      wrap      = 1'b0;
      if (!active_q) begin
         div_cnt_d = '0;
         idx_d     = 2'd0;
         load      = 1'b1;
      end else if (div_cnt_q == DIV_LAST) begin
         div_cnt_d = '0;
         idx_d     = idx_q + 2'd1;
         wrap      = (idx_q == 2'd3);
         load      = wrap;
      end else begin
         div_cnt_d = div_cnt_q + 1'b1;
      end
      shadow_d = load ? digits : shadow_q;
      dp_sh_d  = load ? dp_in : dp_sh_q;
   end

   // A digit blanks only if it and every higher digit are zero with no dp.
   always_comb begin
      blank = blank_lz && (idx_d != 2'd0);
      for (int i = 0; i < 4; i++) begin
         if (i >= int'(idx_d)) begin
            if (shadow_d[4*i +: 4] != 4'd0 || dp_sh_d[i])
               blank = 1'b0;
         end
      end
   end

   always_comb begin
      nib = shadow_d[4*idx_d +: 4];
      unique case (nib)
         4'd0:    seg_d = 7'h40;
         4'd1:    seg_d = 7'h79;
         4'd2:    seg_d = 7'h24;
         4'd3:    seg_d = 7'h30;
         4'd4:    seg_d = 7'h19;
         4'd5:    seg_d = 7'h12;
         4'd6:    seg_d = 7'h02;
         4'd7:    seg_d = 7'h78;
         4'd8:    seg_d = 7'h00;
         4'd9:    seg_d = 7'h10;
         default: seg_d = 7'h3F;
      endcase
      an_d = ~(4'b0001 << idx_d);
      dp_d = ~dp_sh_d[idx_d];
      if (blank) begin
         an_d  = 4'hF;
         seg_d = 7'h7F;
         dp_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt_q <= '0;
         idx_q     <= 2'd0;
         active_q  <= 1'b0;
         shadow_q  <= 16'h0;
         dp_sh_q   <= 4'h0;
         an_q      <= 4'hF;
         seg_q     <= 7'h7F;
         dp_q      <= 1'b1;
         fd_q      <= 1'b0;
      end else if (en) begin
         div_cnt_q <= div_cnt_d;
         idx_q     <= idx_d;
         active_q  <= 1'b1;
         shadow_q  <= shadow_d;
         dp_sh_q   <= dp_sh_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
         fd_q      <= wrap;
      end else begin
         fd_q      <= 1'b0;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Bench for bcd_display_mux: vector table, directed corners, random run.
module tb_bcd_display_mux;

   localparam int R = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b0;
   logic [15:0] digits = 16'h0;
   logic [3:0]  dp_in = 4'h0;
   logic        blank_lz = 1'b0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;

   int errors = 0;
   int checks = 0;

   bcd_display_mux #(.REFRESH_DIV(R)) dut (
      .clk(clk), .reset(reset), .en(en), .digits(digits),
      .dp_in(dp_in), .blank_lz(blank_lz), .an(an), .seg(seg),
      .dp(dp), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] SEGTAB [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   // reference model: cycle position within the frame
   bit          m_active;
   int          m_t;
   logic [15:0] m_sh;
   logic [3:0]  m_dps;
   logic [3:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_dp;
   logic        e_fd;

   task automatic chk(input string name, input logic [12:0] act,
                      input logic [12:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got {an,seg,dp,fd}=%h expected %h",
                  name, act, exp);
      end
   endtask

   task automatic model_out();
      int slot;
      int nib;
      bit blank;
      slot  = m_t / R;
      nib   = int'((m_sh >> (4 * slot)) & 16'hF);
      blank = blank_lz && slot != 0 && ((m_sh >> (4 * slot)) == 0)
              && ((m_dps >> slot) == 0);
      if (blank) begin
         e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
         e_an  = 4'hF;
         e_an[slot] = 1'b0;
         e_seg = (nib < 10) ? SEGTAB[nib] : 7'h3F;
         e_dp  = ~m_dps[slot];
      end
   endtask

   task automatic model_edge();
      if (reset) begin
         m_active = 0; m_t = 0; m_sh = 0; m_dps = 0;
         e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
      end else if (en) begin
         e_fd = 1'b0;
         if (!m_active) begin
            m_active = 1; m_t = 0;
            m_sh = digits; m_dps = dp_in;
         end else begin
            m_t = (m_t + 1) % (4 * R);
            if (m_t == 0) begin
               m_sh = digits; m_dps = dp_in; e_fd = 1'b1;
            end
         end
         model_out();
      end else begin
         e_fd = 1'b0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      model_edge();
      chk("model", {an, seg, dp, frame_done}, {e_an, e_seg, e_dp, e_fd});
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   typedef struct {
      logic [15:0] dig;
      logic [3:0]  dpi;
      logic        blz;
      logic [6:0]  s [4];
      logic [3:0]  d;
      logic [3:0]  blk;
   } vec_t;

   vec_t vt [5];

   initial begin
      vt[0] = '{16'h1234, 4'b0000, 1'b0,
                '{7'h19, 7'h30, 7'h24, 7'h79}, 4'b1111, 4'b0000};
      vt[1] = '{16'h0007, 4'b0100, 1'b1,
                '{7'h78, 7'h40, 7'h40, 7'h7F}, 4'b1011, 4'b1000};
      vt[2] = '{16'h0007, 4'b0000, 1'b1,
                '{7'h78, 7'h7F, 7'h7F, 7'h7F}, 4'b1111, 4'b1110};
      vt[3] = '{16'hF0C9, 4'b0000, 1'b0,
                '{7'h10, 7'h3F, 7'h40, 7'h3F}, 4'b1111, 4'b0000};
      vt[4] = '{16'h5678, 4'b1111, 1'b1,
                '{7'h00, 7'h78, 7'h02, 7'h12}, 4'b0000, 4'b0000};

      // reset held with en high
      reset = 1'b1; en = 1'b1; digits = 16'h1234;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("reset", {an, seg, dp, frame_done},
             {4'hF, 7'h7F, 1'b1, 1'b0});
      end
      reset = 1'b0;

      // vector table, two frames each
      foreach (vt[v]) begin
         do_reset();
         digits = vt[v].dig; dp_in = vt[v].dpi;
         blank_lz = vt[v].blz; en = 1'b1;
         for (int c = 0; c < 8 * R; c++) begin
            int sl;
            logic [3:0] ea;
            step();
            sl = (c / R) % 4;
            ea = 4'hF;
            if (!vt[v].blk[sl]) ea[sl] = 1'b0;
            chk($sformatf("vec%0d_c%0d", v, c),
                {an, seg, dp, frame_done},
                {ea, vt[v].s[sl], vt[v].d[sl],
                 (c == 4 * R) ? 1'b1 : 1'b0});
         end
      end

      // shadowing: change during digit 1
      do_reset();
      digits = 16'h1234; dp_in = 4'h0; blank_lz = 1'b0;
      for (int c = 0; c < 5; c++) step();
      digits = 16'h5678;
      for (int c = 5; c < 4 * R; c++) step();
      chk("shadow_old", {an, seg, dp, frame_done},
          {4'b0111, 7'h79, 1'b1, 1'b0});
      step();
      chk("shadow_new", {an, seg, dp, frame_done},
          {4'b1110, 7'h00, 1'b1, 1'b1});

      // enable drop during digit 2, then mid-frame reset
      do_reset();
      digits = 16'h1234;
      for (int c = 0; c < 2 * R + 2; c++) step();
      en = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         chk("en_hold", {an, seg, dp, frame_done},
             {4'b1011, 7'h24, 1'b1, 1'b0});
      end
      en = 1'b1;
      for (int c = 0; c < R - 2; c++) begin
         step();
         chk("en_resume", {an, seg}, {4'b1011, 7'h24});
      end
      step();
      chk("en_next", {an, seg}, {4'b0111, 7'h79});
      step();
      reset = 1'b1;
      step();
      chk("mid_reset", {an, seg, dp, frame_done},
          {4'hF, 7'h7F, 1'b1, 1'b0});
      reset = 1'b0; digits = 16'h4009;
      step();
      chk("restart", {an, seg, dp, frame_done},
          {4'b1110, 7'h10, 1'b1, 1'b0});

      // randomized run against the model
      for (int n = 0; n < 600; n++) begin
         int m;
         reset = ($urandom_range(0, 59) == 0);
         en = ($urandom_range(0, 6) != 0);
         if ($urandom_range(0, 5) == 0) begin
            m = $urandom_range(0, 4);
            digits = 16'($urandom) & (16'hFFFF >> (4 * m));
         end
         if ($urandom_range(0, 9) == 0) dp_in = 4'($urandom);
         if ($urandom_range(0, 19) == 0) blank_lz = 1'($urandom);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
